// File: rtl/pc_next_sel.sv
// Next-PC select and PC register: sequential step or one of NSRC-1 redirect
// targets, with a one-entry redirect buffer across fetch stalls and misalignment trapping.
module pc_next_sel #(
  parameter int          XLEN       = 32,
  parameter int          NSRC       = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          STEP       = 4,
  parameter int          ALIGN_BITS = 2,
  localparam int         SELW       = $clog2(NSRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NSRC*XLEN-1:0] tgt_vec,
  input  logic [SELW-1:0]      sel,
  output logic [XLEN-1:0]      pc,
  output logic                 pc_valid,
  output logic                 flush,
  output logic                 redirect_pending,
  output logic                 misalign_err,
  output logic [XLEN-1:0]      err_addr
);

  localparam logic [SELW:0] NSRC_W = NSRC[SELW:0];

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] tgt;
  } redir_t;

  logic [NSRC-1:0][XLEN-1:0] tgt_arr;
  logic [SELW-1:0]           sel_eff;
  redir_t                    live, pend;
  logic                      live_mis;

  assign tgt_arr = tgt_vec;

  // Indices past the last source (non-power-of-2 NSRC) fall back to sequential.
  assign sel_eff  = ({1'b0, sel} < NSRC_W) ? sel : '0;
  assign live.vld = (sel_eff != '0);
  assign live.tgt = tgt_arr[sel_eff];
  assign live_mis = live.vld && (|live.tgt[ALIGN_BITS-1:0]);

  assign redirect_pending = pend.vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= XLEN'(RESET_PC);
      pc_valid     <= 1'b0;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
      pend         <= '0;
    end else begin
      pc_valid     <= 1'b1;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      if (live_mis) begin
        // Bad target never reaches pc or the buffer; any buffered redirect survives.
        misalign_err <= 1'b1;
        err_addr     <= live.tgt;
      end else if (stall) begin
        if (live.vld) pend <= live;
      end else if (live.vld) begin
        pc       <= live.tgt;
        flush    <= 1'b1;
        pend.vld <= 1'b0;
      end else if (pend.vld) begin
        pc       <= pend.tgt;
        flush    <= 1'b1;
        pend.vld <= 1'b0;
      end else begin
        pc <= pc + XLEN'(STEP);
      end
    end
  end

endmodule

// File: tb/tb_pc_next_sel.sv
// Directed bench for pc_next_sel: two instances (ALIGN_BITS 2 and 1) share stimulus;
// expected outputs are queued per step and checked after the clock edge.
module tb_pc_next_sel;
  localparam int XLEN = 32;
  localparam int NSRC = 4;

  logic                 clk = 1'b0;
  logic                 rst, stall;
  logic [NSRC*XLEN-1:0] tgt_vec;
  logic [1:0]           sel;
  logic [XLEN-1:0]      pc, err_addr, pc1, err_addr1;
  logic                 pc_valid, flush, pend, merr;
  logic                 pc_valid1, flush1, pend1, merr1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] pc;
    logic            v, fl, pd, me;
    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] pc1;
    logic            fl1, me1;
    logic [XLEN-1:0] ea1;
  } exp_t;

  exp_t sb[$];

  pc_next_sel #(.XLEN(XLEN), .NSRC(NSRC), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .tgt_vec(tgt_vec), .sel(sel),
    .pc(pc), .pc_valid(pc_valid), .flush(flush), .redirect_pending(pend),
    .misalign_err(merr), .err_addr(err_addr));

  pc_next_sel #(.XLEN(XLEN), .NSRC(NSRC), .ALIGN_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .tgt_vec(tgt_vec), .sel(sel),
    .pc(pc1), .pc_valid(pc_valid1), .flush(flush1), .redirect_pending(pend1),
    .misalign_err(merr1), .err_addr(err_addr1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string f, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic st, input logic [1:0] s,
                      input logic [XLEN-1:0] t,
                      input logic [XLEN-1:0] epc, input logic ev, input logic efl, input logic epd,
                      input logic eme, input logic [XLEN-1:0] eea,
                      input logic [XLEN-1:0] epc1, input logic efl1, input logic eme1,
                      input logic [XLEN-1:0] eea1);
    exp_t e;
    rst = r; stall = st; sel = s;
    tgt_vec = '0;
    tgt_vec[s*XLEN +: XLEN] = t;
    e.tag = tag; e.pc = epc; e.v = ev; e.fl = efl; e.pd = epd; e.me = eme; e.ea = eea;
    e.pc1 = epc1; e.fl1 = efl1; e.me1 = eme1; e.ea1 = eea1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "pc",    pc,        e.pc);
    chk(e.tag, "valid", {31'b0, pc_valid}, {31'b0, e.v});
    chk(e.tag, "flush", {31'b0, flush},    {31'b0, e.fl});
    chk(e.tag, "pend",  {31'b0, pend},     {31'b0, e.pd});
    chk(e.tag, "merr",  {31'b0, merr},     {31'b0, e.me});
    chk(e.tag, "eaddr", err_addr,  e.ea);
    chk(e.tag, "pc1",   pc1,       e.pc1);
    chk(e.tag, "valid1", {31'b0, pc_valid1}, {31'b0, e.v});
    chk(e.tag, "flush1", {31'b0, flush1},    {31'b0, e.fl1});
    chk(e.tag, "pend1",  {31'b0, pend1},     {31'b0, e.pd});
    chk(e.tag, "merr1",  {31'b0, merr1},     {31'b0, e.me1});
    chk(e.tag, "eaddr1", err_addr1, e.ea1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; sel = '0; tgt_vec = '0;
    //    tag        rst st sel tgt            pc           v fl pd me ea      pc1          fl1 me1 ea1
    step("rst0",     1, 0, 0, 32'h0,         32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0);
    step("rst1",     1, 0, 0, 32'h0,         32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0);
    step("seq0",     0, 0, 0, 32'h0,         32'h4,        1, 0, 0, 0, 32'h0,  32'h4,        0, 0, 32'h0);
    step("seq1",     0, 0, 0, 32'h0,         32'h8,        1, 0, 0, 0, 32'h0,  32'h8,        0, 0, 32'h0);
    step("redir",    0, 0, 2, 32'h100,       32'h100,      1, 1, 0, 0, 32'h0,  32'h100,      1, 0, 32'h0);
    step("redir+1",  0, 0, 0, 32'h0,         32'h104,      1, 0, 0, 0, 32'h0,  32'h104,      0, 0, 32'h0);
    step("stl1",     0, 1, 1, 32'h200,       32'h104,      1, 0, 1, 0, 32'h0,  32'h104,      0, 0, 32'h0);
    step("stl2",     0, 1, 3, 32'h300,       32'h104,      1, 0, 1, 0, 32'h0,  32'h104,      0, 0, 32'h0);
    step("stl3",     0, 1, 0, 32'h0,         32'h104,      1, 0, 1, 0, 32'h0,  32'h104,      0, 0, 32'h0);
    step("unstl",    0, 0, 0, 32'h0,         32'h300,      1, 1, 0, 0, 32'h0,  32'h300,      1, 0, 32'h0);
    step("unstl+1",  0, 0, 0, 32'h0,         32'h304,      1, 0, 0, 0, 32'h0,  32'h304,      0, 0, 32'h0);
    step("lv_buf",   0, 1, 2, 32'h500,       32'h304,      1, 0, 1, 0, 32'h0,  32'h304,      0, 0, 32'h0);
    step("lv_win",   0, 0, 1, 32'h400,       32'h400,      1, 1, 0, 0, 32'h0,  32'h400,      1, 0, 32'h0);
    step("lv_win+1", 0, 0, 0, 32'h0,         32'h404,      1, 0, 0, 0, 32'h0,  32'h404,      0, 0, 32'h0);
    step("mis",      0, 0, 2, 32'h102,       32'h404,      1, 0, 0, 1, 32'h102, 32'h102,     1, 0, 32'h0);
    step("mis+1",    0, 0, 0, 32'h0,         32'h408,      1, 0, 0, 0, 32'h102, 32'h106,     0, 0, 32'h0);
    step("ms_buf",   0, 1, 1, 32'h600,       32'h408,      1, 0, 1, 0, 32'h102, 32'h106,     0, 0, 32'h0);
    step("ms_stl",   0, 1, 3, 32'h303,       32'h408,      1, 0, 1, 1, 32'h303, 32'h106,     0, 1, 32'h303);
    step("ms_unstl", 0, 0, 0, 32'h0,         32'h600,      1, 1, 0, 0, 32'h303, 32'h600,     1, 0, 32'h303);
    step("wrap_ld",  0, 0, 2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 0, 0, 32'h303, 32'hFFFF_FFFC, 1, 0, 32'h303);
    step("wrap",     0, 0, 0, 32'h0,         32'h0,        1, 0, 0, 0, 32'h303, 32'h0,        0, 0, 32'h303);
    step("pre_rst",  0, 1, 1, 32'h700,       32'h0,        1, 0, 1, 0, 32'h303, 32'h0,        0, 0, 32'h303);
    step("rst_mid",  1, 1, 2, 32'h800,       32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0);
    step("post_rst", 0, 0, 0, 32'h0,         32'h4,        1, 0, 0, 0, 32'h0,  32'h4,        0, 0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
